// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FIFO drain controller.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 8;
   localparam int unsigned CNT_WIDTH_DEF  = 16;

   // Output buffer occupancy; 2'b11 is unused and recovers to S_EMPTY.
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_TWO   = 2'b10
   } state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream seen by the drain controller.
interface fifo_rd_stream_if
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_width = FIFO_WIDTH_DEF
);
   logic                  FIFO_EMPTY;
   logic [FIFO_width-1:0] FIFO_RD_DATA;
   logic                  FIFO_R_INC;
   logic [FIFO_width-1:0] OUT_DATA;
   logic                  OUT_VALID;
   logic                  OUT_READY;

   // Drain controller side.
   modport master (
      input  FIFO_EMPTY, FIFO_RD_DATA, OUT_READY,
      output FIFO_R_INC, OUT_DATA, OUT_VALID
   );

   // FIFO plus consumer side.
   modport slave (
      output FIFO_EMPTY, FIFO_RD_DATA, OUT_READY,
      input  FIFO_R_INC, OUT_DATA, OUT_VALID
   );
endinterface

// File: rtl/word_counter.sv
// Wrapping event counter with enable.
module word_counter
   import fifo_pkg::*;
#(
   parameter int unsigned CNT_width = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   output logic [CNT_width-1:0] cnt_o
);
   logic [CNT_width-1:0] cnt_q, cnt_d;

   // Increment on each enabled cycle; natural overflow gives the wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = cnt_q + CNT_width'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// Pops words from the FIFO read port into a 2-entry buffer and presents them as a
// valid/ready stream; the pop strobe depends on registered occupancy only.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_width = FIFO_WIDTH_DEF,
   parameter int unsigned CNT_width  = CNT_WIDTH_DEF
) (
   input  logic                 R_CLK,
   input  logic                 R_RST,
   input  logic                 EN,
   fifo_rd_stream_if.master     bus,
   output logic [CNT_width-1:0] WORD_CNT
);
   state_e                state_q, state_d;
   logic [FIFO_width-1:0] head_q, head_d;
   logic [FIFO_width-1:0] tail_q, tail_d;
   logic                  valid_c;
   logic                  push_c;
   logic                  pop_c;

   // Push never looks at OUT_READY, so S_TWO blocks it until a slot frees.
   assign valid_c = (state_q != S_EMPTY);
   assign push_c  = R_RST & EN & ~bus.FIFO_EMPTY & (state_q != S_TWO);
   assign pop_c   = valid_c & bus.OUT_READY;

   // Next occupancy and head/tail contents.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         S_EMPTY: begin
            if (push_c) begin
               state_d = S_ONE;
               head_d  = bus.FIFO_RD_DATA;
            end
         end
         S_ONE: begin
            if (push_c && pop_c) begin
               head_d = bus.FIFO_RD_DATA;
            end else if (push_c) begin
               state_d = S_TWO;
               tail_d  = bus.FIFO_RD_DATA;
            end else if (pop_c) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (pop_c) begin
               state_d = S_ONE;
               head_d  = tail_q;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   // Buffer state registers.
   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) begin
         state_q <= S_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign bus.FIFO_R_INC = push_c;
   assign bus.OUT_DATA   = head_q;
   assign bus.OUT_VALID  = valid_c;

   // Completed output handshakes.
   word_counter #(
      .CNT_width (CNT_width)
   ) u_word_counter (
      .clk   (R_CLK),
      .rst_n (R_RST),
      .en_i  (pop_c),
      .cnt_o (WORD_CNT)
   );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, scoreboard monitor,
// per-cycle vector table and hand-written corner sequences.
module tb_fifo_rd_stream;
   import fifo_pkg::*;

   logic        R_CLK = 1'b0;
   logic        R_RST;
   logic        EN;
   logic [15:0] WORD_CNT;

   logic        rst4;
   logic        en4;
   logic [3:0]  cnt4;

   always #5 R_CLK = ~R_CLK;

   fifo_rd_stream_if #(.FIFO_width(8)) bus ();
   fifo_rd_stream_if #(.FIFO_width(8)) bus4 ();

   fifo_rd_stream #(.FIFO_width(8), .CNT_width(16)) dut (
      .R_CLK    (R_CLK),
      .R_RST    (R_RST),
      .EN       (EN),
      .bus      (bus),
      .WORD_CNT (WORD_CNT)
   );

   fifo_rd_stream #(.FIFO_width(8), .CNT_width(4)) dut4 (
      .R_CLK    (R_CLK),
      .R_RST    (rst4),
      .EN       (en4),
      .bus      (bus4),
      .WORD_CNT (cnt4)
   );

   int         errors = 0;
   int         checks = 0;
   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   bit         pend_pop = 1'b0;
   int         n_deliv = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic void upd_fifo();
      bus.FIFO_EMPTY = (fq.size() == 0);
      if (fq.size() != 0) bus.FIFO_RD_DATA = fq[0];
      else                bus.FIFO_RD_DATA = 8'h00;
   endfunction

   // Advance one cycle; the FIFO model consumes the word popped at this edge.
   task automatic tick();
      @(posedge R_CLK);
      #1;
      if (pend_pop) begin
         if (fq.size() != 0) void'(fq.pop_front());
         pend_pop = 1'b0;
      end
      upd_fifo();
   endtask

   task automatic clear_all();
      R_RST = 1'b0;
      fq.delete();
      exp_q.delete();
      pend_pop = 1'b0;
      upd_fifo();
   endtask

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge R_CLK) begin
      chk("inc_legal", 32'(bus.FIFO_R_INC && (bus.FIFO_EMPTY || exp_q.size() >= 2)), 32'd0);
      chk("valid_vs_model", 32'(bus.OUT_VALID), 32'(exp_q.size() != 0));
      if (bus.OUT_VALID && exp_q.size() != 0) begin
         chk("out_data", 32'(bus.OUT_DATA), 32'(exp_q[0]));
         if (bus.OUT_READY) begin
            void'(exp_q.pop_front());
            n_deliv++;
         end
      end
      if (bus.FIFO_R_INC && !bus.FIFO_EMPTY) begin
         exp_q.push_back(bus.FIFO_RD_DATA);
         pend_pop = 1'b1;
      end
   end

   typedef struct {
      logic        rst;
      logic        en;
      logic        rdy;
      logic        inc;
      logic        valid;
      logic [7:0]  data;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int hs4;

      // rst, en, rdy  ->  inc, valid, data, cnt
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 16'd0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 16'd0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 16'd1};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 16'd2};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 16'd2};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 16'd3};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 16'd4};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA3, 16'd4};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};

      R_RST = 1'b0;
      EN = 1'b1;
      bus.OUT_READY = 1'b0;
      rst4 = 1'b0;
      en4 = 1'b1;
      bus4.FIFO_EMPTY = 1'b0;
      bus4.FIFO_RD_DATA = 8'h3C;
      bus4.OUT_READY = 1'b0;
      for (int i = 0; i < 8; i++) fq.push_back(8'(8'hA0 + i));
      upd_fifo();

      // Reset, release, backpressure to S_TWO, EN drop and reset mid-stream.
      for (int i = 0; i < 13; i++) begin
         tick();
         if (R_RST && !vecs[i].rst) clear_all();
         R_RST = vecs[i].rst;
         EN = vecs[i].en;
         bus.OUT_READY = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d_inc", i),   32'(bus.FIFO_R_INC), 32'(vecs[i].inc));
         chk($sformatf("vec%0d_valid", i), 32'(bus.OUT_VALID),  32'(vecs[i].valid));
         chk($sformatf("vec%0d_data", i),  32'(bus.OUT_DATA),   32'(vecs[i].data));
         chk($sformatf("vec%0d_cnt", i),   32'(WORD_CNT),       32'(vecs[i].cnt));
      end

      // Streaming: 16 words on consecutive cycles.
      tick();
      clear_all();
      for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
      upd_fifo();
      EN = 1'b1;
      bus.OUT_READY = 1'b1;
      base = n_deliv;
      tick();
      R_RST = 1'b1;
      #1;
      chk("stream_inc_on_release", 32'(bus.FIFO_R_INC), 32'd1);
      tick();
      chk("stream_first_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("stream_first_data", 32'(bus.OUT_DATA), 32'h01);
      repeat (16) tick();
      chk("stream_delivered", 32'(n_deliv - base), 32'd16);
      chk("stream_cnt", 32'(WORD_CNT), 32'd16);
      chk("stream_final_empty", 32'(bus.OUT_VALID), 32'd0);

      // Random ready over 1000 words.
      tick();
      clear_all();
      for (int i = 0; i < 1000; i++) fq.push_back(8'($urandom));
      upd_fifo();
      EN = 1'b1;
      base = n_deliv;
      tick();
      R_RST = 1'b1;
      for (int c = 0; c < 6000 && (n_deliv - base) < 1000; c++) begin
         tick();
         bus.OUT_READY = 1'($urandom_range(0, 1));
      end
      chk("rand_delivered", 32'(n_deliv - base), 32'd1000);
      chk("rand_cnt", 32'(WORD_CNT), 32'd1000);
      chk("rand_fifo_drained", 32'(fq.size()), 32'd0);

      // EN drop with two words buffered, then reset while in S_TWO.
      tick();
      clear_all();
      for (int i = 0; i < 10; i++) fq.push_back(8'(8'h50 + i));
      upd_fifo();
      EN = 1'b1;
      bus.OUT_READY = 1'b0;
      base = n_deliv;
      tick();
      R_RST = 1'b1;
      tick();
      tick();
      chk("en_full_no_inc", 32'(bus.FIFO_R_INC), 32'd0);
      bus.OUT_READY = 1'b1;
      tick();
      bus.OUT_READY = 1'b0;
      tick();
      EN = 1'b0;
      #1;
      chk("en_off_inc", 32'(bus.FIFO_R_INC), 32'd0);
      chk("en_three_taken", 32'(fq.size()), 32'd7);
      bus.OUT_READY = 1'b1;
      repeat (4) tick();
      chk("en_no_more_taken", 32'(fq.size()), 32'd7);
      chk("en_buffer_drained", 32'(n_deliv - base), 32'd3);
      chk("en_cnt", 32'(WORD_CNT), 32'd3);
      chk("en_idle_valid", 32'(bus.OUT_VALID), 32'd0);
      EN = 1'b1;
      bus.OUT_READY = 1'b0;
      tick();
      tick();
      chk("two_before_rst_valid", 32'(bus.OUT_VALID), 32'd1);
      clear_all();
      #1;
      chk("rst_in_two_valid", 32'(bus.OUT_VALID), 32'd0);
      chk("rst_in_two_cnt", 32'(WORD_CNT), 32'd0);
      chk("rst_in_two_inc", 32'(bus.FIFO_R_INC), 32'd0);

      // Counter wrap on a 4-bit instance: 17 handshakes.
      tick();
      rst4 = 1'b1;
      bus4.OUT_READY = 1'b1;
      hs4 = 0;
      for (int c = 0; c < 200 && hs4 < 17; c++) begin
         @(negedge R_CLK);
         if (bus4.OUT_VALID) begin
            hs4++;
            if (hs4 == 16) begin
               @(posedge R_CLK);
               #1;
               chk("wrap_at_16", 32'(cnt4), 32'd0);
            end
         end
      end
      @(posedge R_CLK);
      #1;
      bus4.OUT_READY = 1'b0;
      en4 = 1'b0;
      chk("wrap_hs_count", 32'(hs4), 32'd17);
      tick();
      tick();
      chk("wrap_cnt", 32'(cnt4), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
